// File: rtl/kernel_run_ctrl.sv
// Run controller and array-port arbiter for one generated kernel instance.
// Latency: start->LAUNCH 1 cycle, host write 1 cycle, host read data 2 cycles after grant; start stalls host until run end.
module kernel_run_ctrl #(
    parameter int ADDR_W = 1,
    parameter int DATA_W = 1,
    parameter int ARG_W  = 1,
    parameter int RES_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ARG_W-1:0]  start_arg,
    output logic              busy,
    output logic              done,
    output logic [RES_W-1:0]  result,
    output logic [CNT_W-1:0]  run_cycles,
    output logic              timeout,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              k_r_enable,
    output logic [ARG_W-1:0]  k_init,
    input  logic              k_w_enable,
    input  logic [RES_W-1:0]  k_result,
    output logic              k_ctl,
    output logic              k_ctl_we,
    output logic [ADDR_W-1:0] k_ctl_addr,
    output logic [DATA_W-1:0] k_ctl_wdata,
    input  logic [DATA_W-1:0] k_ctl_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD     = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    state_t              state_q, state_d;
    logic [ARG_W-1:0]    arg_q, arg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    run_cycles_q, run_cycles_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic                timeout_q, timeout_d;
    logic                done_q, done_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                run_end_ok;
    logic                run_end_to;

    // A run ends either on the kernel's completion flag or when the counter would saturate.
    assign run_end_ok = (state_q == ST_RUN) && k_w_enable;
    assign run_end_to = (state_q == ST_RUN) && !k_w_enable && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LAUNCH;
                end else if (host_req && !host_we) begin
                    state_d = ST_RD;
                end
            end
            ST_RD:     state_d = ST_IDLE;
            ST_LAUNCH: state_d = ST_RUN;
            ST_RUN: begin
                if (run_end_ok || run_end_to) begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        k_ctl       = 1'b0;
        busy        = 1'b0;
        k_r_enable  = 1'b0;
        host_gnt    = 1'b0;
        k_ctl_we    = 1'b0;
        k_ctl_addr  = '0;
        k_ctl_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                k_ctl = 1'b1;
                if (!start && host_req) begin
                    host_gnt    = 1'b1;
                    k_ctl_we    = host_we;
                    k_ctl_addr  = host_addr;
                    k_ctl_wdata = host_wdata;
                end
            end
            ST_RD: begin
                k_ctl = 1'b1;
            end
            ST_LAUNCH: begin
                busy       = 1'b1;
                k_r_enable = 1'b1;
            end
            ST_RUN: begin
                busy = 1'b1;
            end
            default: begin
                k_ctl = 1'b1;
            end
        endcase
    end

    always_comb begin
        arg_d        = arg_q;
        cnt_d        = cnt_q;
        run_cycles_d = run_cycles_q;
        result_d     = result_q;
        timeout_d    = timeout_q;
        done_d       = 1'b0;
        rvalid_d     = 1'b0;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    arg_d = start_arg;
                end
            end
            ST_RD: begin
                rvalid_d = 1'b1;
                rdata_d  = k_ctl_rdata;
            end
            ST_LAUNCH: begin
                cnt_d        = '0;
                run_cycles_d = '0;
                timeout_d    = 1'b0;
            end
            ST_RUN: begin
                if (k_w_enable) begin
                    result_d     = k_result;
                    run_cycles_d = cnt_q;
                    done_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (run_end_to) begin
                        timeout_d    = 1'b1;
                        run_cycles_d = cnt_q + CNT_ONE;
                        done_d       = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arg_q        <= '0;
            cnt_q        <= '0;
            run_cycles_q <= '0;
            result_q     <= '0;
            timeout_q    <= 1'b0;
            done_q       <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            arg_q        <= arg_d;
            cnt_q        <= cnt_d;
            run_cycles_q <= run_cycles_d;
            result_q     <= result_d;
            timeout_q    <= timeout_d;
            done_q       <= done_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign k_init      = arg_q;
    assign done        = done_q;
    assign result      = result_q;
    assign run_cycles  = run_cycles_q;
    assign timeout     = timeout_q;
    assign host_rvalid = rvalid_q;
    assign host_rdata  = rdata_q;

endmodule

// File: tb/tb_kernel_run_ctrl.sv
// Directed bench: instance A drives a behavioural complexIf-like kernel with a 2-word array,
// instance B (CNT_W=4) has a hand-driven completion flag for timeout behaviour.
module tb_kernel_run_ctrl;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    // Instance A signals
    logic       a_start, a_start_arg, a_busy, a_done, a_timeout;
    logic [1:0] a_result;
    logic [15:0] a_run_cycles;
    logic       a_host_req, a_host_we, a_host_addr, a_host_wdata;
    logic       a_host_gnt, a_host_rvalid, a_host_rdata;
    logic       a_k_r_enable, a_k_init, a_k_w_enable;
    logic [1:0] a_k_result;
    logic       a_k_ctl, a_k_ctl_we, a_k_ctl_addr, a_k_ctl_wdata, a_k_ctl_rdata;

    // Instance B signals
    logic       b_start, b_busy, b_done, b_timeout;
    logic [1:0] b_result;
    logic [3:0] b_run_cycles;
    logic       b_host_gnt, b_host_rvalid, b_host_rdata;
    logic       b_k_r_enable, b_k_init, b_wen;
    logic [1:0] b_kres;
    logic       b_k_ctl, b_k_ctl_we, b_k_ctl_addr, b_k_ctl_wdata;

    kernel_run_ctrl #(.ADDR_W(1), .DATA_W(1), .ARG_W(1), .RES_W(2), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n),
        .start(a_start), .start_arg(a_start_arg),
        .busy(a_busy), .done(a_done), .result(a_result),
        .run_cycles(a_run_cycles), .timeout(a_timeout),
        .host_req(a_host_req), .host_we(a_host_we), .host_addr(a_host_addr),
        .host_wdata(a_host_wdata), .host_gnt(a_host_gnt),
        .host_rvalid(a_host_rvalid), .host_rdata(a_host_rdata),
        .k_r_enable(a_k_r_enable), .k_init(a_k_init),
        .k_w_enable(a_k_w_enable), .k_result(a_k_result),
        .k_ctl(a_k_ctl), .k_ctl_we(a_k_ctl_we), .k_ctl_addr(a_k_ctl_addr),
        .k_ctl_wdata(a_k_ctl_wdata), .k_ctl_rdata(a_k_ctl_rdata)
    );

    kernel_run_ctrl #(.ADDR_W(1), .DATA_W(1), .ARG_W(1), .RES_W(2), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .start(b_start), .start_arg(1'b0),
        .busy(b_busy), .done(b_done), .result(b_result),
        .run_cycles(b_run_cycles), .timeout(b_timeout),
        .host_req(1'b0), .host_we(1'b0), .host_addr(1'b0),
        .host_wdata(1'b0), .host_gnt(b_host_gnt),
        .host_rvalid(b_host_rvalid), .host_rdata(b_host_rdata),
        .k_r_enable(b_k_r_enable), .k_init(b_k_init),
        .k_w_enable(b_wen), .k_result(b_kres),
        .k_ctl(b_k_ctl), .k_ctl_we(b_k_ctl_we), .k_ctl_addr(b_k_ctl_addr),
        .k_ctl_wdata(b_k_ctl_wdata), .k_ctl_rdata(1'b0)
    );

    always #5 clk = ~clk;

    // Kernel model: arg 0 finishes 9 cycles after r_enable with result 2, arg 1 after 8 with result 3.
    // The completion flag stays high until the next r_enable, and the kernel clears array word 0.
    logic       k_run, k_hold, k_arg, k_fin;
    logic [3:0] k_cnt;
    logic       arr [0:1];
    logic       rd_q;

    assign k_fin         = k_run && (k_cnt == (k_arg ? 4'd7 : 4'd8));
    assign a_k_w_enable  = k_hold | k_fin;
    assign a_k_result    = k_arg ? 2'd3 : 2'd2;
    assign a_k_ctl_rdata = rd_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_run  <= 1'b0;
            k_hold <= 1'b0;
            k_arg  <= 1'b0;
            k_cnt  <= 4'd0;
        end else if (a_k_r_enable) begin
            k_run  <= 1'b1;
            k_hold <= 1'b0;
            k_arg  <= a_k_init;
            k_cnt  <= 4'd0;
        end else if (k_run) begin
            k_cnt <= k_cnt + 4'd1;
            if (k_fin) begin
                k_run  <= 1'b0;
                k_hold <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (a_k_ctl && a_k_ctl_we) arr[a_k_ctl_addr] <= a_k_ctl_wdata;
        else if (k_fin) arr[0] <= 1'b0;
        rd_q <= arr[a_k_ctl_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_a(output int n);
        n = 0;
        while (!a_done && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_b(output int n);
        n = 0;
        while (!b_done && n < 40) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        tests = 0; fails = 0;
        clk = 0; rst_n = 0;
        a_start = 0; a_start_arg = 0;
        a_host_req = 0; a_host_we = 0; a_host_addr = 0; a_host_wdata = 0;
        b_start = 0; b_wen = 0; b_kres = 2'd2;

        #2;
        chk("rst_busy", a_busy, 0);
        chk("rst_kctl", a_k_ctl, 1);
        chk("rst_renable", a_k_r_enable, 0);
        chk("rst_result", a_result, 0);
        chk("rst_cycles", a_run_cycles, 0);
        chk("rst_timeout", a_timeout, 0);
        chk("rst_rvalid", a_host_rvalid, 0);
        chk("rst_rdata", a_host_rdata, 0);
        chk("rst_done", a_done, 0);
        tick(); tick();
        rst_n = 1;

        // Host write addr0=1, then read it back
        a_host_req = 1; a_host_we = 1; a_host_addr = 0; a_host_wdata = 1;
        #1;
        chk("wr_gnt", a_host_gnt, 1);
        chk("wr_kwe", a_k_ctl_we, 1);
        tick();
        a_host_we = 0; a_host_wdata = 0;
        #1;
        chk("rd_gnt", a_host_gnt, 1);
        tick();
        a_host_req = 0;
        #1;
        chk("rd_rvalid_t1", a_host_rvalid, 0);
        chk("rd_gnt_in_rd", a_host_gnt, 0);
        tick();
        chk("rd_rvalid_t2", a_host_rvalid, 1);
        chk("rd_rdata", a_host_rdata, 1);

        // Run with arg 0
        a_start = 1; a_start_arg = 0;
        tick();
        a_start = 0;
        #1;
        chk("a0_renable", a_k_r_enable, 1);
        chk("a0_busy", a_busy, 1);
        chk("a0_kctl", a_k_ctl, 0);
        wait_a(n);
        chk("a0_done_lat", n + 1, 11);
        chk("a0_result", a_result, 2);
        chk("a0_cycles", a_run_cycles, 8);
        chk("a0_busy_end", a_busy, 0);
        tick();
        chk("a0_done_pulse", a_done, 0);
        a_host_req = 1; a_host_we = 0; a_host_addr = 0;
        #1;
        chk("a0_rd_gnt", a_host_gnt, 1);
        tick();
        a_host_req = 0;
        tick();
        chk("a0_rd_rvalid", a_host_rvalid, 1);
        chk("a0_rd_rdata", a_host_rdata, 0);

        // Run with arg 1 while a host read is pending
        a_start = 1; a_start_arg = 1;
        a_host_req = 1; a_host_we = 0; a_host_addr = 0;
        #1;
        chk("a1_gnt_blocked", a_host_gnt, 0);
        tick();
        a_start = 0;
        #1;
        chk("a1_gnt_launch", a_host_gnt, 0);
        chk("a1_init", a_k_init, 1);
        wait_a(n);
        chk("a1_done_lat", n + 1, 10);
        chk("a1_result", a_result, 3);
        chk("a1_cycles", a_run_cycles, 7);
        chk("a1_gnt_after", a_host_gnt, 1);
        tick();
        a_host_req = 0;
        tick();
        chk("a1_rd_rvalid", a_host_rvalid, 1);
        chk("a1_rd_rdata", a_host_rdata, 0);

        // Back-to-back runs: completion flag still high in second LAUNCH
        a_start = 1; a_start_arg = 0;
        tick();
        a_start = 0;
        wait_a(n);
        a_start = 1;
        tick();
        a_start = 0;
        #1;
        chk("b2b_wen_in_launch", a_k_w_enable, 1);
        chk("b2b_renable", a_k_r_enable, 1);
        wait_a(n);
        chk("b2b_done_lat", n + 1, 11);
        chk("b2b_cycles", a_run_cycles, 8);
        chk("b2b_result", a_result, 2);

        // Reset mid-RUN
        a_start = 1; a_start_arg = 0;
        tick();
        a_start = 0;
        tick(); tick(); tick();
        chk("mr_busy_before", a_busy, 1);
        rst_n = 0;
        #1;
        chk("mr_busy", a_busy, 0);
        chk("mr_kctl", a_k_ctl, 1);
        chk("mr_renable", a_k_r_enable, 0);
        chk("mr_result", a_result, 0);
        chk("mr_cycles", a_run_cycles, 0);
        chk("mr_done", a_done, 0);
        tick();
        rst_n = 1;

        // Instance B: short run for a nonzero result, then a timeout run
        b_start = 1;
        tick();
        b_start = 0;
        tick(); tick();
        b_wen = 1;
        tick();
        b_wen = 0;
        b_kres = 2'd1;
        chk("b_done", b_done, 1);
        chk("b_result", b_result, 2);
        chk("b_cycles", b_run_cycles, 1);
        b_start = 1;
        tick();
        b_start = 0;
        wait_b(n);
        chk("to_done_lat", n + 1, 17);
        chk("to_timeout", b_timeout, 1);
        chk("to_result", b_result, 2);
        chk("to_cycles", b_run_cycles, 15);
        chk("to_busy", b_busy, 0);
        tick();
        chk("to_sticky", b_timeout, 1);
        b_start = 1;
        tick();
        b_start = 0;
        tick();
        chk("to_cleared", b_timeout, 0);
        chk("to_busy_again", b_busy, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
